rvfi_retire_checker: RTL and testbench
======================================

# rvfi_retire_checker

Consumer end of the reference-model RVFI stream. Takes two retirement streams: the DUT RVFI retirement and the reference-model RVFI output, which can arrive skewed in time. Each stream is buffered in its own FIFO, and entries are popped pairwise in retirement order. The selected fields are compared and a per-instruction verdict is emitted, along with sticky error, overflow and timeout status for the testbench scoreboard.

## Interface
- DEPTH, 8: entries per side FIFO; power of two, ≥2.
- TIMEOUT, 1024: cycles one side may hold entries while the other is empty before timeout_o sets.
- STOP_ON_MISMATCH, 1: 1 = stop popping after the first mismatch.
- clk_i  in  1  clock. One clock; reset is synchronous and active-high.
- rst_i  in  1  synchronous active-high reset.
- dut_valid_i  in  1  DUT retirement strobe, one instruction per cycle.
- dut_order_i  in  64  retirement order.
- dut_insn_i  in  32  instruction word.
- dut_trap_i  in  1  trap flag.
- dut_intr_i  in  1  first instruction of interrupt handler.
- dut_pc_rdata_i  in  32  PC of instruction.
- dut_pc_wdata_i  in  32  next PC.
- dut_rd1_addr_i  in  5  destination register.
- dut_rd1_wdata_i  in  32  destination write data.
- ref_valid_i, ref_order_i, ref_insn_i, ref_trap_i, ref_intr_i, ref_pc_rdata_i, ref_pc_wdata_i, ref_rd1_addr_i, ref_rd1_wdata_i  in  same widths  reference-model stream.
- cmp_valid_o  out  1  verdict strobe.
- cmp_match_o  out  1  1 = all compared fields equal.
- cmp_field_mask_o  out  8  per-field mismatch bits.
- cmp_order_o  out  64  DUT order of compared pair.
- mismatch_count_o  out  32  mismatches so far, saturating.
- dut_level_o, ref_level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow_o  out  1  sticky: an entry was dropped.
- timeout_o  out  1  sticky: skew timeout.
- error_o  out  1  sticky: mismatch, overflow or timeout.

## Operation
- Push:
  - Each side writes its fields into its FIFO on the edge where valid is high.
  - A push into a full FIFO is accepted only if a pop happens on the same edge. Otherwise the entry is dropped and overflow_o sets.
- Pop:
  - Occurs on any edge where both FIFOs are non-empty and the unit is not halted.
  - Pops one entry from each side.
  - The compare result is registered.
- cmp_field_mask_o bit meanings (bit = 1 on mismatch):
  - 0: order.
  - 1: insn.
  - 2: trap.
  - 3: pc_rdata.
  - 4: pc_wdata.
  - 5: rd1_addr.
  - 6: rd1_wdata. Compared only when DUT rd1_addr≠0; otherwise the bit is 0.
  - 7: intr.
- cmp_match_o = (mask == 0).
- Mismatch side effects:
  - mismatch_count_o increments, saturating at 32'hFFFF_FFFF.
  - error_o sets.
  - If STOP_ON_MISMATCH=1, the unit enters HALTED. Pushes continue, subject to overflow rules; pops stop until reset.
- States:
  - RUN → HALTED on a mismatch with STOP_ON_MISMATCH=1.
  - HALTED exits only via rst_i.
- Skew counter:
  - Increments each cycle exactly one FIFO is non-empty and the other is empty.
  - Clears when both are empty or both are non-empty.
  - When the counter reaches TIMEOUT, timeout_o sets. The counter then holds.
- error_o = sticky OR of mismatch, overflow_o and timeout_o.
- FIFO pointers wrap modulo DEPTH. Levels range 0..DEPTH.

## Timing
- Latency:
  - Valid sampled at edge N; entry visible from edge N.
  - Pop at edge N+1 at the earliest.
  - cmp_valid_o is high for exactly one cycle after the pop edge, i.e. 2 cycles after a simultaneous push on both sides.
- Throughput: one compare per cycle when both streams are steady.
- Simultaneous push and pop on the same side: level is unchanged; the new entry lands behind the popped one.
- cmp_valid_o is 0 on every cycle without a pop. cmp_match_o, cmp_field_mask_o and cmp_order_o hold their last values.
- Sticky flags update on the edge after the causing event.
- Reset values: all outputs 0, FIFOs empty, state RUN, skew counter 0.
- Reset mid-stream: all in-flight entries are discarded. Inputs sampled on the reset edge are ignored.

## Test plan
- Lockstep stream: both sides push identical order 0..99, one per cycle.
  - Required: 100 cmp_valid_o pulses, each with match=1.
  - First pulse 2 cycles after the first push; mismatch_count_o=0; error_o=0.
- Skew: DUT pushes 5 entries; ref pushes the same 5 entries starting 6 cycles later.
  - Required: dut_level_o peaks at 5.
  - Verdicts begin 2 cycles after the first ref push; all match.
  - timeout_o=0 with TIMEOUT=1024.
- Data mismatch: entry with order 7 has ref rd1_wdata=32'h1234 vs DUT 32'h1235, rd1_addr=5.
  - Required: mask=8'h40, match=0, mismatch_count_o=1, error_o=1.
  - With STOP_ON_MISMATCH=1, no further cmp_valid_o pulses occur.
- rd1_addr=0: rd1_wdata differs on both sides.
  - Required: mask=0, match=1.
- Overflow: DEPTH=8; DUT pushes 9 entries with no ref pushes.
  - Required: level=8, overflow_o=1 the cycle after the 9th push.
  - The 9th entry is never compared.
- Timeout and reset: TIMEOUT=16; DUT pushes 1 entry; ref stays idle.
  - Required: timeout_o=1 after 16 skew cycles.
  - Asserting rst_i for one cycle clears every output and both levels to 0.

Source files
------------

// File: rtl/rvfi_retire_checker.sv
// Pairs DUT and reference-model RVFI retirements through two skew-absorbing FIFOs and
// emits a registered per-instruction verdict plus sticky mismatch/overflow/timeout status.
module rvfi_retire_checker #(
    parameter int DEPTH            = 8,
    parameter int TIMEOUT          = 1024,
    parameter bit STOP_ON_MISMATCH = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       dut_valid_i,
    input  logic [63:0]                dut_order_i,
    input  logic [31:0]                dut_insn_i,
    input  logic                       dut_trap_i,
    input  logic                       dut_intr_i,
    input  logic [31:0]                dut_pc_rdata_i,
    input  logic [31:0]                dut_pc_wdata_i,
    input  logic [4:0]                 dut_rd1_addr_i,
    input  logic [31:0]                dut_rd1_wdata_i,
    input  logic                       ref_valid_i,
    input  logic [63:0]                ref_order_i,
    input  logic [31:0]                ref_insn_i,
    input  logic                       ref_trap_i,
    input  logic                       ref_intr_i,
    input  logic [31:0]                ref_pc_rdata_i,
    input  logic [31:0]                ref_pc_wdata_i,
    input  logic [4:0]                 ref_rd1_addr_i,
    input  logic [31:0]                ref_rd1_wdata_i,
    output logic                       cmp_valid_o,
    output logic                       cmp_match_o,
    output logic [7:0]                 cmp_field_mask_o,
    output logic [63:0]                cmp_order_o,
    output logic [31:0]                mismatch_count_o,
    output logic [$clog2(DEPTH):0]     dut_level_o,
    output logic [$clog2(DEPTH):0]     ref_level_o,
    output logic                       overflow_o,
    output logic                       timeout_o,
    output logic                       error_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] FULL_LVL    = LW'(DEPTH);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic        intr;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rd1_addr;
        logic [31:0] rd1_wdata;
    } entry_t;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

    entry_t          dut_mem_r [DEPTH];
    entry_t          ref_mem_r [DEPTH];
    logic [AW-1:0]   dut_wr_ptr_r, dut_rd_ptr_r, ref_wr_ptr_r, ref_rd_ptr_r;
    logic [LW-1:0]   dut_level_r, ref_level_r;
    logic [CW-1:0]   skew_cnt_r;
    state_t          state_r;
    logic            cmp_valid_r, cmp_match_r, overflow_r, timeout_r, error_r;
    logic [7:0]      cmp_mask_r;
    logic [63:0]     cmp_order_r;
    logic [31:0]     mismatch_cnt_r;

    entry_t          dut_in_s, ref_in_s, dut_head_s, ref_head_s;
    logic            pop_s, dut_push_s, ref_push_s, drop_s, mismatch_s, one_side_s, timeout_s;
    logic [7:0]      mask_s;

    assign dut_in_s   = {dut_order_i, dut_insn_i, dut_trap_i, dut_intr_i,
                         dut_pc_rdata_i, dut_pc_wdata_i, dut_rd1_addr_i, dut_rd1_wdata_i};
    assign ref_in_s   = {ref_order_i, ref_insn_i, ref_trap_i, ref_intr_i,
                         ref_pc_rdata_i, ref_pc_wdata_i, ref_rd1_addr_i, ref_rd1_wdata_i};
    assign dut_head_s = dut_mem_r[dut_rd_ptr_r];
    assign ref_head_s = ref_mem_r[ref_rd_ptr_r];

    // Pop/push qualification and field-by-field comparison of the two FIFO heads.
    always_comb begin
        pop_s      = (dut_level_r != '0) && (ref_level_r != '0) && (state_r == ST_RUN);
        dut_push_s = dut_valid_i && ((dut_level_r != FULL_LVL) || pop_s);
        ref_push_s = ref_valid_i && ((ref_level_r != FULL_LVL) || pop_s);
        drop_s     = (dut_valid_i && !dut_push_s) || (ref_valid_i && !ref_push_s);
        mask_s     = 8'h00;
        mask_s[0]  = dut_head_s.order    != ref_head_s.order;
        mask_s[1]  = dut_head_s.insn     != ref_head_s.insn;
        mask_s[2]  = dut_head_s.trap     != ref_head_s.trap;
        mask_s[3]  = dut_head_s.pc_rdata != ref_head_s.pc_rdata;
        mask_s[4]  = dut_head_s.pc_wdata != ref_head_s.pc_wdata;
        mask_s[5]  = dut_head_s.rd1_addr != ref_head_s.rd1_addr;
        mask_s[6]  = (dut_head_s.rd1_addr != 5'd0) && (dut_head_s.rd1_wdata != ref_head_s.rd1_wdata);
        mask_s[7]  = dut_head_s.intr     != ref_head_s.intr;
        mismatch_s = pop_s && (mask_s != 8'h00);
        one_side_s = (dut_level_r != '0) != (ref_level_r != '0);
        timeout_s  = (skew_cnt_r == TIMEOUT_CNT);
    end

    // FIFO storage; a full FIFO that pops on the same edge writes into the slot being freed.
    always_ff @(posedge clk_i) begin
        if (!rst_i && dut_push_s) begin
            dut_mem_r[dut_wr_ptr_r] <= dut_in_s;
        end
        if (!rst_i && ref_push_s) begin
            ref_mem_r[ref_wr_ptr_r] <= ref_in_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dut_wr_ptr_r <= '0;
            dut_rd_ptr_r <= '0;
            ref_wr_ptr_r <= '0;
            ref_rd_ptr_r <= '0;
            dut_level_r  <= '0;
            ref_level_r  <= '0;
        end else begin
            dut_wr_ptr_r <= dut_push_s ? dut_wr_ptr_r + AW'(1) : dut_wr_ptr_r;
            ref_wr_ptr_r <= ref_push_s ? ref_wr_ptr_r + AW'(1) : ref_wr_ptr_r;
            dut_rd_ptr_r <= pop_s ? dut_rd_ptr_r + AW'(1) : dut_rd_ptr_r;
            ref_rd_ptr_r <= pop_s ? ref_rd_ptr_r + AW'(1) : ref_rd_ptr_r;
            case ({dut_push_s, pop_s})
                2'b10:   dut_level_r <= dut_level_r + LW'(1);
                2'b01:   dut_level_r <= dut_level_r - LW'(1);
                default: dut_level_r <= dut_level_r;
            endcase
            case ({ref_push_s, pop_s})
                2'b10:   ref_level_r <= ref_level_r + LW'(1);
                2'b01:   ref_level_r <= ref_level_r - LW'(1);
                default: ref_level_r <= ref_level_r;
            endcase
        end
    end

    // Verdict registers and the RUN/HALTED state machine.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r        <= ST_RUN;
            cmp_valid_r    <= 1'b0;
            cmp_match_r    <= 1'b0;
            cmp_mask_r     <= 8'h00;
            cmp_order_r    <= 64'd0;
            mismatch_cnt_r <= 32'd0;
        end else begin
            cmp_valid_r <= pop_s;
            if (pop_s) begin
                cmp_match_r <= (mask_s == 8'h00);
                cmp_mask_r  <= mask_s;
                cmp_order_r <= dut_head_s.order;
            end
            if (mismatch_s && (mismatch_cnt_r != 32'hFFFF_FFFF)) begin
                mismatch_cnt_r <= mismatch_cnt_r + 32'd1;
            end
            case (state_r)
                ST_RUN:    state_r <= (mismatch_s && STOP_ON_MISMATCH) ? ST_HALTED : ST_RUN;
                ST_HALTED: state_r <= ST_HALTED;
                default:   state_r <= ST_RUN;
            endcase
        end
    end

    // Skew counter (holds at TIMEOUT) and sticky status flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            skew_cnt_r <= '0;
            overflow_r <= 1'b0;
            timeout_r  <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            if (!one_side_s) begin
                skew_cnt_r <= '0;
            end else if (skew_cnt_r != TIMEOUT_CNT) begin
                skew_cnt_r <= skew_cnt_r + CW'(1);
            end else begin
                skew_cnt_r <= skew_cnt_r;
            end
            overflow_r <= overflow_r | drop_s;
            timeout_r  <= timeout_r | timeout_s;
            error_r    <= error_r | mismatch_s | drop_s | timeout_s;
        end
    end

    assign cmp_valid_o      = cmp_valid_r;
    assign cmp_match_o      = cmp_match_r;
    assign cmp_field_mask_o = cmp_mask_r;
    assign cmp_order_o      = cmp_order_r;
    assign mismatch_count_o = mismatch_cnt_r;
    assign dut_level_o      = dut_level_r;
    assign ref_level_o      = ref_level_r;
    assign overflow_o       = overflow_r;
    assign timeout_o        = timeout_r;
    assign error_o          = error_r;
endmodule

// File: tb/tb_rvfi_retire_checker.sv
// Directed and randomized retirement streams checked cycle by cycle against a queue-based
// model of the pairing checker.
module tb_rvfi_retire_checker;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam bit STOP    = 1'b1;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic        intr;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rd1_addr;
        logic [31:0] rd1_wdata;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        dut_v = 1'b0, ref_v = 1'b0;
    ent_t        dut_e = '0, ref_e = '0;
    logic        cmp_valid_o, cmp_match_o, overflow_o, timeout_o, error_o;
    logic [7:0]  cmp_field_mask_o;
    logic [63:0] cmp_order_o;
    logic [31:0] mismatch_count_o;
    logic [3:0]  dut_level_o, ref_level_o;

    always #5 clk_i = ~clk_i;

    rvfi_retire_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STOP_ON_MISMATCH(STOP)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .dut_valid_i(dut_v), .dut_order_i(dut_e.order), .dut_insn_i(dut_e.insn),
        .dut_trap_i(dut_e.trap), .dut_intr_i(dut_e.intr), .dut_pc_rdata_i(dut_e.pc_rdata),
        .dut_pc_wdata_i(dut_e.pc_wdata), .dut_rd1_addr_i(dut_e.rd1_addr),
        .dut_rd1_wdata_i(dut_e.rd1_wdata),
        .ref_valid_i(ref_v), .ref_order_i(ref_e.order), .ref_insn_i(ref_e.insn),
        .ref_trap_i(ref_e.trap), .ref_intr_i(ref_e.intr), .ref_pc_rdata_i(ref_e.pc_rdata),
        .ref_pc_wdata_i(ref_e.pc_wdata), .ref_rd1_addr_i(ref_e.rd1_addr),
        .ref_rd1_wdata_i(ref_e.rd1_wdata),
        .cmp_valid_o(cmp_valid_o), .cmp_match_o(cmp_match_o),
        .cmp_field_mask_o(cmp_field_mask_o), .cmp_order_o(cmp_order_o),
        .mismatch_count_o(mismatch_count_o), .dut_level_o(dut_level_o),
        .ref_level_o(ref_level_o), .overflow_o(overflow_o), .timeout_o(timeout_o),
        .error_o(error_o)
    );

    // Reference model state
    ent_t        dq[$], rq[$];
    bit          halted;
    int          run;
    logic        m_valid, m_match, m_ovf, m_to, m_err;
    logic [7:0]  m_mask;
    logic [63:0] m_order;
    logic [31:0] m_cnt;
    int          n_vec = 0, n_err = 0, n_pulse = 0, peak = 0;

    function automatic ent_t rand_ent(input logic [63:0] ord);
        ent_t e;
        e.order     = ord;
        e.insn      = $urandom;
        e.trap      = ($urandom_range(0, 7) == 0);
        e.intr      = ($urandom_range(0, 7) == 0);
        e.pc_rdata  = $urandom;
        e.pc_wdata  = $urandom;
        e.rd1_addr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        e.rd1_wdata = $urandom;
        return e;
    endfunction

    function automatic logic [7:0] diff(input ent_t a, input ent_t b);
        logic [7:0] m;
        m = {a.intr != b.intr,
             (a.rd1_addr != 5'd0) && (a.rd1_wdata != b.rd1_wdata),
             a.rd1_addr != b.rd1_addr, a.pc_wdata != b.pc_wdata,
             a.pc_rdata != b.pc_rdata, a.trap != b.trap,
             a.insn != b.insn, a.order != b.order};
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        if (cmp_valid_o === 1'b1) n_pulse++;
        if (int'(dut_level_o) > peak) peak = int'(dut_level_o);
        chk("cmp_valid", 64'(cmp_valid_o), 64'(m_valid));
        chk("cmp_match", 64'(cmp_match_o), 64'(m_match));
        chk("cmp_mask", 64'(cmp_field_mask_o), 64'(m_mask));
        chk("cmp_order", cmp_order_o, m_order);
        chk("mismatch_count", 64'(mismatch_count_o), 64'(m_cnt));
        chk("dut_level", 64'(dut_level_o), 64'(dq.size()));
        chk("ref_level", 64'(ref_level_o), 64'(rq.size()));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        chk("timeout", 64'(timeout_o), 64'(m_to));
        chk("error", 64'(error_o), 64'(m_err));
    endtask

    task automatic model_clear();
        dq.delete(); rq.delete();
        halted = 1'b0; run = 0;
        m_valid = 1'b0; m_match = 1'b0; m_mask = 8'h00; m_order = 64'd0;
        m_cnt = 32'd0; m_ovf = 1'b0; m_to = 1'b0; m_err = 1'b0;
    endtask

    // One clock: drive, advance the model by one edge, then compare all outputs.
    task automatic tick(input bit dv, input ent_t de, input bit rv, input ent_t re);
        bit   d_ne, r_ne;
        ent_t a, b;
        dut_v = dv; dut_e = de; ref_v = rv; ref_e = re;
        d_ne = (dq.size() != 0);
        r_ne = (rq.size() != 0);
        if (run == TIMEOUT) begin m_to = 1'b1; m_err = 1'b1; end
        run = (d_ne != r_ne) ? ((run < TIMEOUT) ? run + 1 : run) : 0;
        m_valid = d_ne && r_ne && !halted;
        if (m_valid) begin
            a = dq.pop_front();
            b = rq.pop_front();
            m_mask  = diff(a, b);
            m_match = (m_mask == 8'h00);
            m_order = a.order;
            if (!m_match) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                m_err  = 1'b1;
                halted = STOP;
            end
        end
        if (dv) begin
            if (dq.size() < DEPTH) dq.push_back(de); else begin m_ovf = 1'b1; m_err = 1'b1; end
        end
        if (rv) begin
            if (rq.size() < DEPTH) rq.push_back(re); else begin m_ovf = 1'b1; m_err = 1'b1; end
        end
        @(posedge clk_i); #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, '0, 1'b0, '0);
    endtask

    // Reset with valid inputs asserted: those samples must be ignored.
    task automatic do_reset();
        rst_i = 1'b1;
        dut_v = 1'b1; dut_e = rand_ent(64'd99); ref_v = 1'b1; ref_e = rand_ent(64'd77);
        @(posedge clk_i); #1;
        rst_i = 1'b0; dut_v = 1'b0; ref_v = 1'b0;
        model_clear();
        check_all();
        n_pulse = 0; peak = 0;
    endtask

    initial begin
        ent_t e, r;
        ent_t saved[$];
        ent_t pend[$];
        logic [63:0] ord;
        model_clear();
        #1;
        do_reset();

        // Lockstep 0..99
        for (int i = 0; i < 100; i++) begin
            e = rand_ent(64'(i));
            tick(1'b1, e, 1'b1, e);
        end
        idle(3);
        chk("lockstep_pulses", 64'(n_pulse), 64'd100);
        chk("lockstep_error", 64'(error_o), 64'd0);

        // Skew: ref starts 6 cycles after DUT
        do_reset();
        saved.delete();
        for (int i = 0; i < 5; i++) begin
            e = rand_ent(64'(i)); saved.push_back(e);
            tick(1'b1, e, 1'b0, '0);
        end
        idle(1);
        for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b1, saved[i]);
        idle(3);
        chk("skew_peak", 64'(peak), 64'd5);
        chk("skew_pulses", 64'(n_pulse), 64'd5);
        chk("skew_timeout", 64'(timeout_o), 64'd0);

        // rd1_wdata mismatch at order 7
        do_reset();
        for (int i = 0; i < 11; i++) begin
            e = rand_ent(64'(i)); e.rd1_addr = 5'd5; e.rd1_wdata = 32'h1235;
            r = e;
            if (i == 7) r.rd1_wdata = 32'h1234;
            tick(1'b1, e, 1'b1, r);
        end
        idle(4);
        chk("mm_mask", 64'(cmp_field_mask_o), 64'h40);
        chk("mm_match", 64'(cmp_match_o), 64'd0);
        chk("mm_count", 64'(mismatch_count_o), 64'd1);
        chk("mm_error", 64'(error_o), 64'd1);
        chk("mm_pulses", 64'(n_pulse), 64'd8);

        // rd1_addr = 0 hides rd1_wdata difference
        do_reset();
        for (int i = 0; i < 3; i++) begin
            e = rand_ent(64'(i)); e.rd1_addr = 5'd0;
            r = e; r.rd1_wdata = ~e.rd1_wdata;
            tick(1'b1, e, 1'b1, r);
        end
        idle(2);
        chk("x0_mask", 64'(cmp_field_mask_o), 64'h00);
        chk("x0_match", 64'(cmp_match_o), 64'd1);

        // Overflow: 9 DUT pushes, then ref supplies the first 8
        do_reset();
        saved.delete();
        for (int i = 0; i < 9; i++) begin
            e = rand_ent(64'(i)); saved.push_back(e);
            tick(1'b1, e, 1'b0, '0);
        end
        chk("ovf_level", 64'(dut_level_o), 64'd8);
        chk("ovf_flag", 64'(overflow_o), 64'd1);
        for (int i = 0; i < 8; i++) tick(1'b0, '0, 1'b1, saved[i]);
        idle(3);
        chk("ovf_pulses", 64'(n_pulse), 64'd8);
        chk("ovf_last_order", cmp_order_o, 64'd7);

        // Timeout, then reset clears everything
        do_reset();
        tick(1'b1, rand_ent(64'd0), 1'b0, '0);
        idle(15);
        chk("to_early", 64'(timeout_o), 64'd0);
        idle(4);
        chk("to_set", 64'(timeout_o), 64'd1);
        do_reset();
        chk("rst_level", 64'(dut_level_o), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);

        // Randomized skewed streams with occasional corruption
        for (int round = 0; round < 4; round++) begin
            do_reset();
            pend.delete();
            ord = 64'd0;
            for (int c = 0; c < 100; c++) begin
                bit dv, rv;
                dv = ($urandom_range(0, 2) != 0);
                e = '0;
                if (dv) begin
                    e = rand_ent(ord); ord++;
                    pend.push_back(e);
                end
                rv = (pend.size() != 0) && ($urandom_range(0, 2) != 0);
                r = '0;
                if (rv) begin
                    r = pend.pop_front();
                    if ($urandom_range(0, 39) == 0) begin
                        case ($urandom_range(0, 3))
                            0:       r.insn     = r.insn ^ 32'h1;
                            1:       r.pc_wdata = r.pc_wdata + 32'd4;
                            2:       r.trap     = ~r.trap;
                            default: r.rd1_addr = r.rd1_addr ^ 5'd1;
                        endcase
                    end
                end
                tick(dv, e, rv, r);
            end
            idle(10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
